// File: rtl/edge_pkg.sv
// Shared types and default widths for the Sobel edge streaming engine.
package edge_pkg;

  localparam int PIX_W_DEF = 4;
  localparam int SUM_W     = PIX_W_DEF + 2;
  localparam int MAG_W     = PIX_W_DEF + 3;

  // Magnitude approximation: L1 norm, or max plus half of min.
  typedef enum logic {
    MAG_L1      = 1'b0,
    MAG_MAXHALF = 1'b1
  } mag_mode_e;

  // 3x3 window at the default pixel width, indexed [row][col], row 0 = top.
  typedef logic [2:0][2:0][PIX_W_DEF-1:0] pix_win_t;

endpackage

// File: rtl/sobel_axis_grad.sv
// One Sobel axis: two weighted 1-2-1 sums (stage 2) and their absolute
// difference (stage 3). Both registers advance only on the shared enable.
module sobel_axis_grad
  import edge_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               i_en,
  input  logic [PIX_W-1:0]   i_a0,
  input  logic [PIX_W-1:0]   i_a1,
  input  logic [PIX_W-1:0]   i_a2,
  input  logic [PIX_W-1:0]   i_b0,
  input  logic [PIX_W-1:0]   i_b1,
  input  logic [PIX_W-1:0]   i_b2,
  output logic [PIX_W+1:0]   o_grad
);

  localparam int L_SUM_W = PIX_W + 2;

  logic [L_SUM_W-1:0] w_sum_a;
  logic [L_SUM_W-1:0] w_sum_b;
  logic [L_SUM_W-1:0] r_sum_a;
  logic [L_SUM_W-1:0] r_sum_b;
  logic [L_SUM_W-1:0] w_diff;
  logic [L_SUM_W-1:0] r_grad;

  // Weighted sums: outer taps x1, middle tap x2; 4*(2^PIX_W-1) fits in PIX_W+2 bits.
  assign w_sum_a = {2'b00, i_a0} + {1'b0, i_a1, 1'b0} + {2'b00, i_a2};
  assign w_sum_b = {2'b00, i_b0} + {1'b0, i_b1, 1'b0} + {2'b00, i_b2};

  // Compare-then-subtract keeps the difference unsigned and non-negative.
  assign w_diff = (r_sum_a >= r_sum_b) ? (r_sum_a - r_sum_b) : (r_sum_b - r_sum_a);

  // Stage 2 register: the two sums.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sum_a <= '0;
      r_sum_b <= '0;
    end else if (i_en) begin
      r_sum_a <= w_sum_a;
      r_sum_b <= w_sum_b;
    end
  end

  // Stage 3 register: absolute gradient along this axis.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_grad <= '0;
    end else if (i_en) begin
      r_grad <= w_diff;
    end
  end

  assign o_grad = r_grad;

endmodule

// File: rtl/sobel_edge_stream.sv
// Five-stage Sobel gradient-magnitude pipeline with valid/ready on both sides,
// optional thresholding and a saturating count of nonzero results.
//
// Handshake: a window transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. The whole pipeline (bubbles
// included) advances on en = out_ready || !out_valid, and in_ready = en, so a
// stalled result holds out_valid/edge_val stable and nothing is lost or doubled.
module sobel_edge_stream
  import edge_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int OUT_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0][2:0][PIX_W-1:0]   pix,
  input  logic                         mag_mode,
  input  logic                         thr_en,
  input  logic [PIX_W+2:0]             thresh,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             edge_val,
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             edge_cnt
);

  localparam int L_SUM_W = PIX_W + 2;
  localparam int L_MAG_W = PIX_W + 3;

  logic                        w_en;
  // Stage valids; stage 5 is the output register.
  logic                        r_v1, r_v2, r_v3, r_v4, r_v5;
  // Stage 1: captured window and sideband.
  logic [2:0][2:0][PIX_W-1:0]  r_pix;
  mag_mode_e                   r_mode1, r_mode2, r_mode3;
  logic                        r_thr1, r_thr2, r_thr3, r_thr4;
  logic [L_MAG_W-1:0]          r_th1, r_th2, r_th3, r_th4;
  // Stage 3 gradients from the axis units.
  logic [L_SUM_W-1:0]          w_gx, w_gy;
  // Stage 4 magnitude.
  logic [L_SUM_W-1:0]          w_max, w_min;
  logic [L_MAG_W-1:0]          w_mag;
  logic [L_MAG_W-1:0]          r_mag;
  // Stage 5 result.
  logic [OUT_W-1:0]            w_edge;
  logic [OUT_W-1:0]            r_edge;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_fire_nz;

  assign w_en     = out_ready || !r_v5;
  assign in_ready = w_en;

  // Stage 1: capture the window and its per-window controls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_v1    <= 1'b0;
      r_pix   <= '0;
      r_mode1 <= MAG_L1;
      r_thr1  <= 1'b0;
      r_th1   <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_pix   <= pix;
      r_mode1 <= mag_mode_e'(mag_mode);
      r_thr1  <= thr_en;
      r_th1   <= thresh;
    end
  end

  // Horizontal gradient: left column vs right column.
  sobel_axis_grad #(.PIX_W(PIX_W)) u_grad_x (
    .clk    (clk),
    .nreset (nreset),
    .i_en   (w_en),
    .i_a0   (r_pix[0][0]),
    .i_a1   (r_pix[1][0]),
    .i_a2   (r_pix[2][0]),
    .i_b0   (r_pix[0][2]),
    .i_b1   (r_pix[1][2]),
    .i_b2   (r_pix[2][2]),
    .o_grad (w_gx)
  );

  // Vertical gradient: top row vs bottom row.
  sobel_axis_grad #(.PIX_W(PIX_W)) u_grad_y (
    .clk    (clk),
    .nreset (nreset),
    .i_en   (w_en),
    .i_a0   (r_pix[0][0]),
    .i_a1   (r_pix[0][1]),
    .i_a2   (r_pix[0][2]),
    .i_b0   (r_pix[2][0]),
    .i_b1   (r_pix[2][1]),
    .i_b2   (r_pix[2][2]),
    .o_grad (w_gy)
  );

  // Stages 2-3: carry valid and sideband alongside the axis units.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_mode2 <= MAG_L1;
      r_mode3 <= MAG_L1;
      r_thr2  <= 1'b0;
      r_thr3  <= 1'b0;
      r_th2   <= '0;
      r_th3   <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      r_mode2 <= r_mode1;
      r_mode3 <= r_mode2;
      r_thr2  <= r_thr1;
      r_thr3  <= r_thr2;
      r_th2   <= r_th1;
      r_th3   <= r_th2;
    end
  end

  // Magnitude: L1 sum, or max + min/2; worst case 8*(2^PIX_W-1) fits MAG_W.
  assign w_max = (w_gx >= w_gy) ? w_gx : w_gy;
  assign w_min = (w_gx >= w_gy) ? w_gy : w_gx;
  assign w_mag = (r_mode3 == MAG_L1)
               ? ({1'b0, w_gx} + {1'b0, w_gy})
               : ({1'b0, w_max} + {2'b00, w_min[L_SUM_W-1:1]});

  // Stage 4: register magnitude with its output controls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_v4   <= 1'b0;
      r_mag  <= '0;
      r_thr4 <= 1'b0;
      r_th4  <= '0;
    end else if (w_en) begin
      r_v4   <= r_v3;
      r_mag  <= w_mag;
      r_thr4 <= r_thr3;
      r_th4  <= r_th3;
    end
  end

  // Quantise to the top OUT_W bits, or reduce to all-ones/zero against thresh.
  assign w_edge = r_thr4 ? ((r_mag >= r_th4) ? {OUT_W{1'b1}} : {OUT_W{1'b0}})
                         : r_mag[L_MAG_W-1 -: OUT_W];

  // Stage 5: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_v5   <= 1'b0;
      r_edge <= '0;
    end else if (w_en) begin
      r_v5   <= r_v4;
      r_edge <= w_edge;
    end
  end

  assign w_fire_nz = r_v5 && out_ready && (r_edge != '0);

  // Saturating count of nonzero results; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_fire_nz && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = r_v5;
  assign edge_val  = r_edge;
  assign edge_cnt  = r_cnt;

endmodule
